// File: rtl/bbot_uart_route_switch_if.sv
// Control/status bundle between the BBot register block (master) and the UART
// route switch (slave).
interface bbot_uart_route_switch_if #(
  parameter int NUM_CH = 4
);
  localparam int CH_W = $clog2(NUM_CH);

  logic            route_req;
  logic            route_en;
  logic [CH_W-1:0] route_a;
  logic [CH_W-1:0] route_b;
  logic            route_ack;
  logic            route_err;
  logic            busy;
  logic            link_active;
  logic [CH_W-1:0] cur_a;
  logic [CH_W-1:0] cur_b;
  logic            timeout;

  modport master (
    output route_req, route_en, route_a, route_b,
    input  route_ack, route_err, busy, link_active, cur_a, cur_b, timeout
  );

  modport slave (
    input  route_req, route_en, route_a, route_b,
    output route_ack, route_err, busy, link_active, cur_a, cur_b, timeout
  );
endinterface

// File: rtl/bbot_uart_route_switch.sv
// Glitch-free point-to-point UART line router between NUM_CH endpoints.
// Optional forced switch on a stuck line is enabled with `define ROUTE_TIMEOUT_EN.
module bbot_uart_route_switch #(
  parameter int NUM_CH         = 4,
  parameter int SYNC_STAGES    = 2,
  parameter int IDLE_CYCLES    = 1100,
  parameter int GUARD_CYCLES   = 64,
  parameter int TIMEOUT_CYCLES = 1000000
) (
  input  logic              clock,
  input  logic              reset_l,
  input  logic [NUM_CH-1:0] tx_in,
  output logic [NUM_CH-1:0] rx_out,
  bbot_uart_route_switch_if.slave ctl
);
  localparam int CH_W    = $clog2(NUM_CH);
  localparam int MAX_IG  = (IDLE_CYCLES > GUARD_CYCLES) ? IDLE_CYCLES : GUARD_CYCLES;
  localparam int CNT_MAX = (MAX_IG > TIMEOUT_CYCLES) ? MAX_IG : TIMEOUT_CYCLES;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  typedef logic [CNT_W-1:0] cnt_t;
  typedef enum logic [1:0] {UNLINKED, LINKED, DRAIN, GUARD} state_e;

  function automatic cnt_t sat_inc(input cnt_t v);
    return (v == cnt_t'(CNT_MAX)) ? v : v + 1'b1;
  endfunction

  state_e          state_q;
  cnt_t            cnt_q;
  logic [CH_W-1:0] pend_a_q, pend_b_q, cur_a_q, cur_b_q;
  logic            pend_en_q;
  logic            ack_q, err_q, busy_q, link_q;
  logic [NUM_CH-1:0] tx_s, rx_d, rx_q;
`ifdef ROUTE_TIMEOUT_EN
  cnt_t            tmo_q;
  logic            timeout_q;
  cnt_t            tmo_nxt;
  assign tmo_nxt = sat_inc(tmo_q);
`endif

  // Per-lane metastability chain; idles at mark so reset never shows a start bit.
  for (genvar i = 0; i < NUM_CH; i++) begin : g_lane
    logic [SYNC_STAGES-1:0] sync_q;
    always_ff @(posedge clock or negedge reset_l) begin
      if (!reset_l) sync_q <= '1;
      else          sync_q <= {sync_q[SYNC_STAGES-2:0], tx_in[i]};
    end
    assign tx_s[i] = sync_q[SYNC_STAGES-1];
  end

  logic req_ok, line_idle, fwd;
  cnt_t idle_nxt;
  assign req_ok    = !ctl.route_en ||
                     (int'(ctl.route_a) < NUM_CH && int'(ctl.route_b) < NUM_CH &&
                      ctl.route_a != ctl.route_b);
  assign line_idle = tx_s[cur_a_q] & tx_s[cur_b_q];
  assign idle_nxt  = line_idle ? sat_inc(cnt_q) : '0;
  assign fwd       = (state_q == LINKED) || (state_q == DRAIN);

  always_comb begin
    rx_d = '1;
    if (fwd) begin
      rx_d[cur_b_q] = tx_s[cur_a_q];
      rx_d[cur_a_q] = tx_s[cur_b_q];
    end
  end

  always_ff @(posedge clock or negedge reset_l) begin
    if (!reset_l) rx_q <= '1;
    else          rx_q <= rx_d;
  end

  always_ff @(posedge clock or negedge reset_l) begin
    if (!reset_l) begin
      state_q   <= UNLINKED;
      cnt_q     <= '0;
      pend_a_q  <= '0;
      pend_b_q  <= '0;
      pend_en_q <= 1'b0;
      cur_a_q   <= '0;
      cur_b_q   <= '0;
      ack_q     <= 1'b0;
      err_q     <= 1'b0;
      busy_q    <= 1'b0;
      link_q    <= 1'b0;
`ifdef ROUTE_TIMEOUT_EN
      tmo_q     <= '0;
      timeout_q <= 1'b0;
`endif
    end else begin
      ack_q <= 1'b0;
      err_q <= 1'b0;
`ifdef ROUTE_TIMEOUT_EN
      timeout_q <= 1'b0;
`endif
      case (state_q)
        UNLINKED: begin
          if (ctl.route_req) begin
            if (!req_ok) begin
              err_q <= 1'b1;
            end else if (ctl.route_en) begin
              pend_a_q  <= ctl.route_a;
              pend_b_q  <= ctl.route_b;
              pend_en_q <= 1'b1;
              cnt_q     <= '0;
              busy_q    <= 1'b1;
              state_q   <= GUARD;
            end else begin
              ack_q <= 1'b1;
            end
          end
        end
        LINKED: begin
          if (ctl.route_req) begin
            if (!req_ok) begin
              err_q <= 1'b1;
            end else begin
              pend_a_q  <= ctl.route_a;
              pend_b_q  <= ctl.route_b;
              pend_en_q <= ctl.route_en;
              cnt_q     <= '0;
`ifdef ROUTE_TIMEOUT_EN
              tmo_q     <= '0;
`endif
              busy_q    <= 1'b1;
              link_q    <= 1'b0;
              state_q   <= DRAIN;
            end
          end
        end
        DRAIN: begin
`ifdef ROUTE_TIMEOUT_EN
          tmo_q <= tmo_nxt;
`endif
          if (idle_nxt == cnt_t'(IDLE_CYCLES)) begin
            cnt_q   <= '0;
            state_q <= GUARD;
          end
`ifdef ROUTE_TIMEOUT_EN
          else if (tmo_nxt == cnt_t'(TIMEOUT_CYCLES)) begin
            cnt_q     <= '0;
            timeout_q <= 1'b1;
            state_q   <= GUARD;
          end
`endif
          else begin
            cnt_q <= idle_nxt;
          end
        end
        GUARD: begin
          // Lines are already forced to mark; only the new pair takes effect on exit.
          if (cnt_q == cnt_t'(GUARD_CYCLES - 1)) begin
            busy_q <= 1'b0;
            ack_q  <= 1'b1;
            if (pend_en_q) begin
              cur_a_q <= pend_a_q;
              cur_b_q <= pend_b_q;
              link_q  <= 1'b1;
              state_q <= LINKED;
            end else begin
              cur_a_q <= '0;
              cur_b_q <= '0;
              state_q <= UNLINKED;
            end
          end else begin
            cnt_q <= sat_inc(cnt_q);
          end
        end
        default: state_q <= UNLINKED;
      endcase
    end
  end

  assign rx_out          = rx_q;
  assign ctl.route_ack   = ack_q;
  assign ctl.route_err   = err_q;
  assign ctl.busy        = busy_q;
  assign ctl.link_active = link_q;
  assign ctl.cur_a       = cur_a_q;
  assign ctl.cur_b       = cur_b_q;
`ifdef ROUTE_TIMEOUT_EN
  assign ctl.timeout     = timeout_q;
`else
  assign ctl.timeout     = 1'b0;
`endif
endmodule

// File: doc/bbot_uart_route_switch.md
Name: bbot_uart_route_switch

Overview:
- Parametrised UART line router between NUM_CH serial endpoints (XBee, BBone, text-to-speech module, spare).
- Forms one bidirectional point-to-point link between any two channels: a's TX drives b's RX and b's TX drives a's RX.
- Route changes are glitch-free. The block waits for both linked lines to sit idle, then holds all outputs at mark (1) for a guard interval before switching.
- Sits between FPGA UART pins and the endpoints; driven by the BBot control register block.

Parameters:
- NUM_CH, 4: number of UART channels, >= 2. Localparam CH_W = $clog2(NUM_CH).
- SYNC_STAGES, 2: synchroniser flops per tx_in bit, >= 2.
- IDLE_CYCLES, 1100: consecutive clocks both linked TX lines must be 1 before a switch (>= 1 character time).
- GUARD_CYCLES, 64: clocks all outputs are forced to 1 between routes, >= 1.
- TIMEOUT_CYCLES, 1000000: DRAIN limit, used only with ROUTE_TIMEOUT_EN.

Ports:
- clock  in  1  system clock
- reset_l  in  1  reset; asynchronous assert, active-low
- tx_in  in  NUM_CH  raw TX line from each endpoint (asynchronous)
- rx_out  out  NUM_CH  registered RX line to each endpoint
- route_req  in  1  single-cycle request strobe
- route_en  in  1  1 = link route_a<->route_b; 0 = unlink all
- route_a  in  CH_W  first channel of requested link
- route_b  in  CH_W  second channel of requested link
- route_ack  out  1  one-cycle pulse when a request completes
- route_err  out  1  one-cycle pulse when a request is rejected
- busy  out  1  1 in DRAIN or GUARD
- link_active  out  1  1 in LINKED
- cur_a  out  CH_W  active link channel a (0 when unlinked)
- cur_b  out  CH_W  active link channel b (0 when unlinked)
- timeout  out  1  one-cycle pulse on forced switch; tied 0 without the macro

Behaviour:
- Reset (async, reset_l=0):
  - rx_out all 1.
  - route_ack, route_err, busy, link_active, timeout all 0; cur_a = cur_b = 0.
  - State UNLINKED; counters cleared.
  - Applies immediately, including mid-DRAIN or mid-GUARD.
- tx_in passes through SYNC_STAGES flops; rx_out is registered. Forwarding latency from tx_in to rx_out is SYNC_STAGES+1 clocks.
- Valid request: route_en=0, or (route_a < NUM_CH, route_b < NUM_CH, route_a != route_b).
- Invalid request:
  - route_err pulses 1 cycle after route_req.
  - No state change and no ack.
- route_req is ignored while busy=1; no err and no ack.
- UNLINKED:
  - All rx_out = 1.
  - Valid request with route_en=1: capture pending pair -> GUARD.
  - Request with route_en=0: route_ack next cycle, stay UNLINKED.
- LINKED:
  - rx_out[cur_b] = sync tx[cur_a]; rx_out[cur_a] = sync tx[cur_b]; all other rx_out = 1.
  - Valid request: capture pending pair and enable -> DRAIN.
- DRAIN:
  - Forwarding continues unchanged.
  - idle_cnt increments while both sync tx[cur_a] and sync tx[cur_b] are 1; it clears on any 0.
  - When idle_cnt reaches IDLE_CYCLES -> GUARD.
- GUARD:
  - All rx_out = 1 for exactly GUARD_CYCLES clocks.
  - On exit: if pending enable=1, load cur_a/cur_b -> LINKED; else cur_a = cur_b = 0 -> UNLINKED.
  - route_ack pulses on the exit cycle.
- Requesting the currently active pair still runs the full DRAIN/GUARD sequence.
- Counters are sized for max(IDLE_CYCLES, GUARD_CYCLES, TIMEOUT_CYCLES); they saturate and never wrap.

Optional Feature:
- ROUTE_TIMEOUT_EN defined:
  - A DRAIN cycle counter runs from DRAIN entry.
  - On reaching TIMEOUT_CYCLES: go to GUARD regardless of line activity, and pulse timeout for 1 cycle.
  - route_ack still pulses at GUARD exit.
- Not defined: DRAIN waits indefinitely; timeout is constant 0; no timeout counter is synthesised.

Test Plan (NUM_CH=4, SYNC_STAGES=2, IDLE_CYCLES=16, GUARD_CYCLES=4, TIMEOUT_CYCLES=100):
1. Assert reset_l=0 with tx_in=4'b0000 -> rx_out=4'b1111 asynchronously; busy=0, link_active=0, cur_a=cur_b=0.
2. From UNLINKED, route_req with a=0, b=1, en=1:
   - busy=1 for 4 clocks, then route_ack and link_active=1.
   - tx_in[0] falling edge appears on rx_out[1] exactly 3 clocks later.
   - rx_out[3:2] stay 2'b11.
3. Linked 0<->1, hold tx_in[1]=0, then route_req a=1, b=2:
   - Remains in DRAIN with forwarding active.
   - Release tx_in[1]=1; after 16 idle clocks, rx_out=4'b1111 for 4 clocks, then ack; tx_in[1] now forwards to rx_out[2].
4. route_req with a=2, b=2, then route_req during busy -> route_err pulse (1 cycle) for the first, nothing for the second; cur_a/cur_b unchanged.
5. Drop reset_l mid-GUARD -> rx_out=4'b1111 immediately; after release, state UNLINKED and no ack issued.
6. With ROUTE_TIMEOUT_EN, hold tx_in[0] low in DRAIN -> timeout pulse at DRAIN clock 100, GUARD 4 clocks, then route_ack. Without the macro, the block stays in DRAIN.
